// File: rtl/seq_burst_arbiter.sv
// Round-robin arbiter that gives one shared 4-bit sequence generator to up to four requesters, one burst at a time.
// Optional macro SEQ_ARB_RESTART_EN adds a gen_restart port so that every burst starts at the first sequence word.
module seq_burst_arbiter #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    gen_enable,
  input  logic [3:0]              gen_data,
  output logic                    out_valid,
  output logic [3:0]              out_data,
  output logic [1:0]              out_id
`ifdef SEQ_ARB_RESTART_EN
  ,
  output logic                    gen_restart
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
`ifdef SEQ_ARB_RESTART_EN
  localparam logic [1:0] S_RESTART = 2'd1;
`endif
  localparam logic [1:0] S_BURST   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state;
  logic [1:0]       rr_ptr;
  logic [1:0]       winner;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;

  logic [NREQ-1:0]  rot;
  logic             pick_ok;
  logic [1:0]       pick_off;
  logic [2:0]       pick_sum;
  logic [1:0]       pick;
  logic [LEN_W-1:0] sel_len;
  logic [1:0]       next_ptr;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int j = 0; j < NREQ; j++)
      if (idx == 2'(j)) v[j] = 1'b1;
    return v;
  endfunction

  // Rotate the request vector so that bit 0 is the requester at rr_ptr.
  // The lowest set bit of the rotated vector is then the round-robin winner.
  // NOTE: every variable gets a default first, so no path through this block infers a latch.
  always_comb begin
    rot      = NREQ'({req, req} >> rr_ptr);
    pick_ok  = |rot;
    pick_off = '0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (rot[j]) pick_off = 2'(j);
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    pick     = (pick_sum >= 3'(NREQ)) ? 2'(pick_sum - 3'(NREQ)) : pick_sum[1:0];
    sel_len  = '0;
    for (int j = 0; j < NREQ; j++)
      if (pick == 2'(j)) sel_len = req_len[j*LEN_W +: LEN_W];
    next_ptr = (winner == 2'(NREQ - 1)) ? 2'd0 : winner + 2'd1;
  end

  // These outputs are decoded from the state register only, so no combinational path runs from req.
  assign busy       = (state != S_IDLE);
  assign gen_enable = (state == S_BURST);
`ifdef SEQ_ARB_RESTART_EN
  assign gen_restart = (state == S_RESTART);
`endif

  // NOTE: state and outputs use non-blocking assignments, so every flop samples its pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      grant     <= '0;
      done      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          done      <= '0;
          if (pick_ok) begin
            winner <= pick;
            len_q  <= sel_len;
            cnt    <= '0;
            grant  <= onehot(pick);
            if (sel_len == '0)
              state <= S_DONE;
            else
`ifdef SEQ_ARB_RESTART_EN
              state <= S_RESTART;
`else
              state <= S_BURST;
`endif
          end
        end
`ifdef SEQ_ARB_RESTART_EN
        S_RESTART: state <= S_BURST;
`endif
        S_BURST: begin
          out_valid <= 1'b1;
          out_data  <= gen_data;
          out_id    <= winner;
          cnt       <= cnt + LEN_W'(1);
          if (cnt == len_q - LEN_W'(1)) begin
            state <= S_DONE;
            grant <= '0;
            done  <= onehot(winner);
          end
        end
        S_DONE: begin
          out_valid <= 1'b0;
          grant     <= '0;
          // A zero-length burst reaches DONE with grant still set, so its done pulse lands one cycle later.
          done      <= (|grant) ? onehot(winner) : '0;
          rr_ptr    <= next_ptr;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_burst_arbiter.sv
// Self-checking bench for seq_burst_arbiter with a behavioural model of the shared sequence generator.
module tb_seq_burst_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [7:0] req_len;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;
  logic       gen_enable;
  logic [3:0] gen_data;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_id;
`ifdef SEQ_ARB_RESTART_EN
  logic       gen_restart;
`endif

  int checks = 0;
  int errors = 0;

  seq_burst_arbiter #(.NREQ(2), .LEN_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_len    (req_len),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .gen_enable (gen_enable),
    .gen_data   (gen_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id)
`ifdef SEQ_ARB_RESTART_EN
    ,
    .gen_restart(gen_restart)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: data shows the current word; the position advances on an enabled edge.
  logic [3:0] seq_rom [8];
  logic [2:0] gen_pos;
  logic       gen_rst;
  initial begin
    seq_rom[0] = 4'hA; seq_rom[1] = 4'hB; seq_rom[2] = 4'hE; seq_rom[3] = 4'h7;
    seq_rom[4] = 4'hF; seq_rom[5] = 4'h2; seq_rom[6] = 4'h0; seq_rom[7] = 4'hD;
  end
  always @(posedge clk) begin
`ifdef SEQ_ARB_RESTART_EN
    if (gen_rst || gen_restart) gen_pos <= 3'd0;
`else
    if (gen_rst) gen_pos <= 3'd0;
`endif
    else if (gen_enable) gen_pos <= gen_pos + 3'd1;
  end
  assign gen_data = seq_rom[gen_pos];

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
  } word_t;

  word_t      words[$];
  logic [1:0] done_log[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) words.push_back({out_id, out_data});
      if (done != 2'b00) done_log.push_back(done);
    end
  end

  typedef struct {
    logic [1:0] req;
    logic [3:0] len0;
    logic [1:0] grant;
    logic [1:0] done;
    logic       busy;
    logic       en;
    logic       valid;
    logic [3:0] data;
    logic [1:0] id;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done == 2'b00 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(done != 2'b00), 32'd1);
  endtask

  task automatic clear_logs();
    words.delete();
    done_log.delete();
  endtask

  task automatic gen_restart_bench();
    gen_rst = 1'b1;
    tick();
    gen_rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    word_t      fair_exp[6];
    word_t      wrap_exp[9];
    word_t      drop_exp[4];
    logic [1:0] fair_done_exp[3];
    int         ndone;

    // grant, done, busy, gen_enable, out_valid, out_data, out_id
    tbl[0] = '{2'b01, 4'd3, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0};
    tbl[1] = '{2'b00, 4'd3, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 4'hA, 2'd0};
    tbl[2] = '{2'b00, 4'd3, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 4'hB, 2'd0};
    tbl[3] = '{2'b00, 4'd3, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 4'hE, 2'd0};
    tbl[4] = '{2'b00, 4'd3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[5] = '{2'b01, 4'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[6] = '{2'b00, 4'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[7] = '{2'b00, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};

    fair_exp = '{{2'd0, 4'hA}, {2'd0, 4'hB}, {2'd1, 4'hE}, {2'd1, 4'h7}, {2'd0, 4'hF}, {2'd0, 4'h2}};
    fair_done_exp = '{2'b01, 2'b10, 2'b01};
    wrap_exp = '{{2'd1, 4'hA}, {2'd1, 4'hB}, {2'd1, 4'hE}, {2'd1, 4'h7}, {2'd1, 4'hF},
                 {2'd1, 4'h2}, {2'd1, 4'h0}, {2'd1, 4'hD}, {2'd1, 4'hA}};
    drop_exp = '{{2'd1, 4'hA}, {2'd1, 4'hB}, {2'd1, 4'hE}, {2'd1, 4'h7}};

    reset   = 1'b1;
    gen_rst = 1'b1;
    req     = 2'b00;
    req_len = 8'h00;
    repeat (3) tick();
    check("reset_outputs", {grant, done, busy, gen_enable, out_valid, out_data, out_id},
          32'd0);
    reset   = 1'b0;
    gen_rst = 1'b0;
    clear_logs();

    // Table: a len=3 burst from a freshly reset generator, then a zero-length request.
    for (int i = 0; i < 8; i++) begin
      req     = tbl[i].req;
      req_len = {4'd0, tbl[i].len0};
      tick();
      check($sformatf("tbl%0d_ctrl", i), {grant, done, busy, gen_enable, out_valid},
            {tbl[i].grant, tbl[i].done, tbl[i].busy, tbl[i].en, tbl[i].valid});
      if (tbl[i].valid)
        check($sformatf("tbl%0d_word", i), {out_id, out_data}, {tbl[i].id, tbl[i].data});
    end

    // Fairness: both requesters held with len=2 after a full reset.
    reset   = 1'b1;
    gen_rst = 1'b1;
    tick();
    reset   = 1'b0;
    gen_rst = 1'b0;
    clear_logs();
    req     = 2'b11;
    req_len = {4'd2, 4'd2};
    ndone   = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (done != 2'b00) ndone++;
      if (ndone == 3) break;
    end
    req = 2'b00;
    check("fair_done_count", 32'(ndone), 32'd3);
    repeat (4) tick();
    check("fair_word_count", 32'(words.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < words.size())
        check($sformatf("fair_word%0d", i), 32'(words[i]), 32'(fair_exp[i]));
    for (int i = 0; i < 3; i++)
      if (i < done_log.size())
        check($sformatf("fair_done%0d", i), 32'(done_log[i]), 32'(fair_done_exp[i]));

    // Wrap: len=9 on requester 1 from word A.
    gen_restart_bench();
    req     = 2'b10;
    req_len = {4'd9, 4'd0};
    wait_done("wrap_done_seen", 100);
    req = 2'b00;
    check("wrap_done_vec", 32'(done), 32'd2);
    repeat (3) tick();
    check("wrap_word_count", 32'(words.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < words.size())
        check($sformatf("wrap_word%0d", i), 32'(words[i]), 32'(wrap_exp[i]));

    // Move the pointer to 1, then reset in the 2nd cycle of a len=5 burst.
    req     = 2'b01;
    req_len = {4'd0, 4'd1};
    wait_done("ptr_done_seen", 50);
    req = 2'b00;
    repeat (3) tick();
    req     = 2'b10;
    req_len = {4'd5, 4'd0};
    tick();
    check("mid_grant", 32'(grant), 32'd2);
    tick();
    check("mid_valid_before_reset", 32'(out_valid), 32'd1);
    reset   = 1'b1;
    req     = 2'b11;
    req_len = {4'd1, 4'd1};
    tick();
    check("mid_reset_outputs", {grant, done, busy, gen_enable, out_valid, out_data, out_id},
          32'd0);
    reset = 1'b0;
    tick();
    check("post_reset_grant", 32'(grant), 32'd1);
    req = 2'b00;
    repeat (5) tick();

    // Requester 1 drops req after its first word; the burst still completes.
    gen_restart_bench();
    req     = 2'b10;
    req_len = {4'd4, 4'd0};
    for (int n = 0; n < 50 && !out_valid; n++) tick();
    check("drop_first_word", 32'(out_valid), 32'd1);
    req = 2'b00;
    wait_done("drop_done_seen", 50);
    check("drop_done_vec", 32'(done), 32'd2);
    repeat (3) tick();
    check("drop_word_count", 32'(words.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < words.size())
        check($sformatf("drop_word%0d", i), 32'(words[i]), 32'(drop_exp[i]));
    check("drop_idle", {busy, grant, gen_enable}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
